// File: rtl/snn_mem_tg_pkg.sv
// Shared types and helpers for the SNN memory traffic generator.
package snn_mem_tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } tg_state_e;

  localparam logic [1:0] MODE_WV = 2'd0;
  localparam logic [1:0] MODE_WO = 2'd1;
  localparam logic [1:0] MODE_VO = 2'd2;

  // Linear location index; the pattern word is seed XOR this value.
  function automatic logic [31:0] lin_idx(input int unsigned t, input int unsigned x,
                                          input int unsigned y, input int unsigned xd,
                                          input int unsigned yd);
    return 32'((t * xd + x) * yd + y);
  endfunction

endpackage

// File: rtl/tg_exp_fifo.sv
// Expected-response FIFO: holds {idx, expected data} for each read in flight.
module tg_exp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/snn_mem_traffic_gen.sv
// Sweeps every (t,x,y) location, writes seed^idx, reads back with up to MAX_OUT in flight and checks.
module snn_mem_traffic_gen
  import snn_mem_tg_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int X_DIM   = 5,
  parameter  int Y_DIM   = 5,
  parameter  int T_STEPS = 10,
  parameter  int MAX_OUT = 4,
  parameter  int ERR_W   = 16,
  localparam int XW      = (X_DIM > 1) ? $clog2(X_DIM) : 1,
  localparam int YW      = (Y_DIM > 1) ? $clog2(Y_DIM) : 1,
  localparam int TW      = (T_STEPS > 1) ? $clog2(T_STEPS) : 1,
  localparam int NLOC    = T_STEPS * X_DIM * Y_DIM,
  localparam int IDXW    = (NLOC > 1) ? $clog2(NLOC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [TW-1:0]     req_t,
  output logic [XW-1:0]     req_x,
  output logic [YW-1:0]     req_y,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [TW-1:0]     first_err_t,
  output logic [XW-1:0]     first_err_x,
  output logic [YW-1:0]     first_err_y,
  output logic              proto_err
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  tg_state_e         state_q, state_d;
  logic [TW-1:0]     t_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        mode_q;
  logic [ERR_W-1:0]  err_q;
  logic              fev_q, proto_q;
  logic [TW-1:0]     fe_t_q;
  logic [XW-1:0]     fe_x_q;
  logic [YW-1:0]     fe_y_q;

  logic [IDXW-1:0]        idx_cur, head_idx;
  logic [DATA_W-1:0]      head_exp;
  logic [IDXW+DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]          out_cnt, out_next;
  logic                   xfer, push, pop, last_loc, go;

  assign idx_cur   = IDXW'(lin_idx(32'(t_q), 32'(x_q), 32'(y_q), X_DIM, Y_DIM));
  assign req_write = (state_q == S_WRITE);
  assign req_valid = (state_q == S_WRITE) || ((state_q == S_READ) && (out_cnt < CW'(MAX_OUT)));
  assign req_t     = t_q;
  assign req_x     = x_q;
  assign req_y     = y_q;
  assign req_wdata = seed_q ^ DATA_W'(idx_cur);

  assign go       = (state_q == S_IDLE) && start;
  assign xfer     = req_valid && req_ready;
  assign push     = xfer && (state_q == S_READ);
  assign pop      = rsp_valid && (out_cnt != '0);
  assign out_next = out_cnt + CW'(push) - CW'(pop);
  assign last_loc = (t_q == TW'(T_STEPS - 1)) && (x_q == XW'(X_DIM - 1)) && (y_q == YW'(Y_DIM - 1));

  tg_exp_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IDXW + DATA_W)
  ) u_exp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({idx_cur, req_wdata}),
    .rdata_o (fifo_rdata),
    .count_o (out_cnt)
  );

  assign head_idx = fifo_rdata[IDXW+DATA_W-1:DATA_W];
  assign head_exp = fifo_rdata[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (mode == MODE_VO) ? S_READ : S_WRITE;
      S_WRITE: if (xfer && last_loc) state_d = (mode_q == MODE_WO) ? S_DONE : S_READ;
      S_READ:  if (xfer && last_loc) state_d = S_DRAIN;
      S_DRAIN: if (out_next == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      seed_q  <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        seed_q <= seed;
        mode_q <= mode;
        t_q    <= '0;
        x_q    <= '0;
        y_q    <= '0;
      end else if (xfer) begin
        // y fastest, then x, then t; everything wraps to 0 after the last location
        if (y_q == YW'(Y_DIM - 1)) begin
          y_q <= '0;
          if (x_q == XW'(X_DIM - 1)) begin
            x_q <= '0;
            t_q <= (t_q == TW'(T_STEPS - 1)) ? '0 : t_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end else begin
          y_q <= y_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      fev_q   <= 1'b0;
      fe_t_q  <= '0;
      fe_x_q  <= '0;
      fe_y_q  <= '0;
      proto_q <= 1'b0;
    end else if (go) begin
      err_q   <= '0;
      fev_q   <= 1'b0;
      fe_t_q  <= '0;
      fe_x_q  <= '0;
      fe_y_q  <= '0;
      proto_q <= 1'b0;
    end else if (rsp_valid) begin
      if (!pop) begin
        proto_q <= 1'b1;
      end else if (rsp_data != head_exp) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (!fev_q) begin
          fev_q  <= 1'b1;
          fe_t_q <= TW'(32'(head_idx) / 32'(X_DIM * Y_DIM));
          fe_x_q <= XW'((32'(head_idx) / 32'(Y_DIM)) % 32'(X_DIM));
          fe_y_q <= YW'(32'(head_idx) % 32'(Y_DIM));
        end
      end
    end
  end

  assign busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_t     = fe_t_q;
  assign first_err_x     = fe_x_q;
  assign first_err_y     = fe_y_q;
  assign proto_err       = proto_q;

endmodule
